// File: rtl/mux2_shift_left2_pkg.sv
// Shared defaults and constants for the branch-offset mux/shift block.
// Optional macro BR_TARGET_ADD_EN enables the pc + offset target output in the top.
package mux2_shift_left2_pkg;

  localparam int DEF_DATA_W  = 64;
  localparam int DEF_IMM19_W = 19;
  localparam int DEF_IMM26_W = 26;
  localparam int SHIFT_AMT   = 2;

endpackage

// File: rtl/sign_ext.sv
// Parameterized sign extension: replicates the MSB of din up to OUT_W bits.
module sign_ext #(
  parameter int IN_W  = 19,
  parameter int OUT_W = 64
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);

  assign dout = {{(OUT_W-IN_W){din[IN_W-1]}}, din};

endmodule

// File: rtl/mux2_shift_left2.sv
// Sign-extends two branch immediates, selects one, shifts it left by 2 and registers it.
// Macro BR_TARGET_ADD_EN adds input pc and a registered target = pc + offset.
module mux2_shift_left2
  import mux2_shift_left2_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int IMM19_W = DEF_IMM19_W,
  parameter int IMM26_W = DEF_IMM26_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [IMM19_W-1:0] in_19,
  input  logic [IMM26_W-1:0] in_26,
  input  logic               uncond_br,
  output logic [DATA_W-1:0]  out,
  output logic               out_valid
`ifdef BR_TARGET_ADD_EN
  ,
  input  logic [DATA_W-1:0]  pc,
  output logic [DATA_W-1:0]  target
`endif
);

  logic [DATA_W-1:0] ext_19;
  logic [DATA_W-1:0] ext_26;
  logic [DATA_W-1:0] selected;
  logic [DATA_W-1:0] shifted;

  sign_ext #(.IN_W(IMM19_W), .OUT_W(DATA_W)) u_ext_19 (
    .din  (in_19),
    .dout (ext_19)
  );

  sign_ext #(.IN_W(IMM26_W), .OUT_W(DATA_W)) u_ext_26 (
    .din  (in_26),
    .dout (ext_26)
  );

  assign selected = uncond_br ? ext_26 : ext_19;
  assign shifted  = selected << SHIFT_AMT;

  // out holds across idle cycles; only out_valid tracks in_valid every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= shifted;
      end
    end
  end

`ifdef BR_TARGET_ADD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= '0;
    end else if (in_valid) begin
      target <= pc + shifted;
    end
  end
`else
`endif

endmodule

// File: tb/tb_mux2_shift_left2.sv
// Self-checking bench for mux2_shift_left2: directed scenarios plus randomized traffic
// against an arithmetic reference model (offset = signed immediate * 4 mod 2^64).
module tb_mux2_shift_left2;

  localparam int DATA_W = 64;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [18:0]       in_19;
  logic [25:0]       in_26;
  logic              uncond_br;
  logic [DATA_W-1:0] out;
  logic              out_valid;
`ifdef BR_TARGET_ADD_EN
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] target;
  logic [DATA_W-1:0] model_target;
`endif

  logic [DATA_W-1:0] model_out;
  logic              model_valid;
  int                compared;
  int                mismatched;

  mux2_shift_left2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_19     (in_19),
    .in_26     (in_26),
    .uncond_br (uncond_br),
    .out       (out),
    .out_valid (out_valid)
`ifdef BR_TARGET_ADD_EN
    ,
    .pc        (pc),
    .target    (target)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed value of the selected immediate times four, wrapped to 64 bits.
  function automatic logic [DATA_W-1:0] ref_offset(input logic u, input logic [18:0] a,
                                                   input logic [25:0] b);
    longint v;
    if (u) begin
      v = longint'(b);
      if (b[25]) v = v - (longint'(1) << 26);
    end else begin
      v = longint'(a);
      if (a[18]) v = v - (longint'(1) << 19);
    end
    return 64'(v * 4);
  endfunction

  // Drive one cycle of inputs, update the model, and step to just past the edge.
  task automatic applyStimulus(input logic v, input logic u, input logic [18:0] a,
                               input logic [25:0] b, input logic [DATA_W-1:0] p);
    in_valid  = v;
    uncond_br = u;
    in_19     = a;
    in_26     = b;
`ifdef BR_TARGET_ADD_EN
    pc = p;
    if (v) model_target = p + ref_offset(u, a, b);
`else
    if (p != p) $display("[TB] unused pc");
`endif
    if (v) model_out = ref_offset(u, a, b);
    model_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] exp_out,
                             input logic exp_valid);
    compared++;
    assert (out === exp_out) else begin
      mismatched++;
      $error("[TB] FAIL %s out: observed %h expected %h", tag, out, exp_out);
    end
    compared++;
    assert (out_valid === exp_valid) else begin
      mismatched++;
      $error("[TB] FAIL %s out_valid: observed %b expected %b", tag, out_valid, exp_valid);
    end
`ifdef BR_TARGET_ADD_EN
    compared++;
    assert (target === model_target) else begin
      mismatched++;
      $error("[TB] FAIL %s target: observed %h expected %h", tag, target, model_target);
    end
`endif
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    model_out   = '0;
    model_valid = 1'b0;
`ifdef BR_TARGET_ADD_EN
    model_target = '0;
    pc = '0;
`endif
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    uncond_br = 1'b0;
    in_19     = '0;
    in_26     = '0;

    // Reset state, including a valid input presented while reset is held.
    #2;
    checkOutput("reset", 64'h0, 1'b0);
    in_valid = 1'b1;
    in_19    = 19'h00123;
    @(posedge clk);
    #1;
    checkOutput("reset_hold", 64'h0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed scenarios.
    applyStimulus(1'b1, 1'b0, 19'h00001, 26'h0, 64'h1000);
    checkOutput("imm19_one", 64'h4, 1'b1);
    applyStimulus(1'b1, 1'b0, 19'h7FFFF, 26'h155, 64'h1000);
    checkOutput("imm19_neg1", 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
`ifdef BR_TARGET_ADD_EN
    compared++;
    assert (target === 64'hFFC) else begin
      mismatched++;
      $error("[TB] FAIL target_pc1000: observed %h expected %h", target, 64'hFFC);
    end
`endif
    applyStimulus(1'b1, 1'b1, 19'h3FFFF, 26'h2000000, 64'h0);
    checkOutput("imm26_min", 64'hFFFF_FFFF_F800_0000, 1'b1);
    applyStimulus(1'b1, 1'b1, 19'h40000, 26'h1FFFFFF, 64'h0);
    checkOutput("imm26_max", 64'h0000_0000_07FF_FFFC, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 19'h0, 26'h0, 64'h0);
      checkOutput("idle_hold", 64'h0000_0000_07FF_FFFC, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 19'h3FFFF, 26'h2AAAAAA, 64'h0);
    checkOutput("imm19_max", 64'h0000_0000_000F_FFFC, 1'b1);

    // Select toggles on back-to-back valid cycles with the same immediates.
    applyStimulus(1'b1, 1'b0, 19'h40000, 26'h0000010, 64'h0);
    checkOutput("sel19", 64'hFFFF_FFFF_FFF0_0000, 1'b1);
    applyStimulus(1'b1, 1'b1, 19'h40000, 26'h0000010, 64'h0);
    checkOutput("sel26", 64'h40, 1'b1);
    applyStimulus(1'b1, 1'b0, 19'h40000, 26'h0000010, 64'h0);
    checkOutput("sel19_back", 64'hFFFF_FFFF_FFF0_0000, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom), 19'($urandom),
                    26'($urandom), {$urandom, $urandom});
      checkOutput("random", model_out, model_valid);
    end

    // Asynchronous reset mid-stream, observed before the next edge.
    applyStimulus(1'b1, 1'b1, 19'h0, 26'h0ABCDEF, 64'h2000);
    checkOutput("pre_reset", model_out, 1'b1);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    model_out   = '0;
    model_valid = 1'b0;
`ifdef BR_TARGET_ADD_EN
    model_target = '0;
`endif
    checkOutput("async_reset", 64'h0, 1'b0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_reset_idle", 64'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 19'h00005, 26'h0, 64'h0);
    checkOutput("post_reset_first", 64'h14, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
